instr_fetch: RTL and testbench
==============================

# instr_fetch

Instruction fetch stage of the SIMP 8-bit core, directly upstream of the instruction decoder. Holds the program counter, fetches one instruction byte per memory transaction through a req/ack interface, and buffers up to two fetched bytes in a prefetch queue. Presents the queue head to the decoder through a valid/ready handshake. Supports a redirect (jump) that flushes the queue and restarts fetching at a new address.

## Interface
- ADDR_W, 8: program counter and memory address width.
- RESET_ADDR, 0: PC value loaded at reset.
- clk  in  1  system clock, all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- mem_req  out  1  fetch request; held high until mem_ack.
- mem_addr  out  ADDR_W  fetch address; stable while mem_req high.
- mem_ack  in  1  one-cycle pulse completing the current request; ignored when mem_req low.
- mem_rdata  in  8  instruction byte; valid in the mem_ack cycle.
- instr  out  8  queue head byte, fed to the decoder's instr input.
- instr_pc  out  ADDR_W  address the queue head was fetched from.
- instr_valid  out  1  queue non-empty.
- instr_ready  in  1  consumer takes the head this cycle.
- jump  in  1  redirect pulse; has priority over everything else.
- jump_addr  in  ADDR_W  redirect target; sampled when jump high.

## Operation
- State: pc (next fetch address), 2-entry FIFO of {byte, addr}, count (0..2), FSM {IDLE, FETCH, DISCARD}.
- Reset values: pc = RESET_ADDR, count = 0, FSM = IDLE, mem_req = 0, mem_addr = RESET_ADDR, instr = 0, instr_pc = 0, instr_valid = 0.
- Issue rule: a new request starts only when count + outstanding < 2 after this cycle's push/pop. No overflow is possible.
- IDLE -> FETCH when the issue rule allows. mem_req is driven high and mem_addr is set to pc.
- FETCH on mem_ack: push {mem_rdata, mem_addr}, pc <= pc + 1 (mod 2^ADDR_W, so 0xFF wraps to 0x00).
  - If room remains after the push and any simultaneous pop, stay in FETCH with mem_addr = new pc.
  - Otherwise go to IDLE with mem_req low.
- Pop: instr_valid & instr_ready removes the head. A simultaneous push and pop leaves count unchanged.
- Jump: count <= 0, pc <= jump_addr, and any pop in the same cycle is ignored.
  - From IDLE or FETCH with no ack pending: drop mem_req. The next cycle goes to FETCH at jump_addr.
  - From FETCH with mem_ack in the same cycle: the returned byte is discarded and the request is treated as complete.
  - From FETCH while waiting for ack: mem_req must not be withdrawn. Go to DISCARD, holding mem_req and mem_addr. On mem_ack, drop the data and go to FETCH at jump_addr.
  - Jump during DISCARD: update pc <= jump_addr and stay in DISCARD.
- instr and instr_pc are always the FIFO head, or 0 when empty.

## Timing
- mem_req, mem_addr, instr, instr_pc and instr_valid are all registered outputs.
- First mem_req rises in the first cycle after rst_n deasserts.
- Fetch-to-decode latency: a byte acked in cycle N appears with instr_valid high in cycle N+1.
- Zero-wait memory with ready held high sustains 1 byte per cycle.
- After a jump in cycle N, instr_valid is low from N+1 until the first byte from jump_addr arrives. With zero-wait memory, the earliest case is mem_req high in N+1 and instr_valid high in N+2.
- Asserting rst_n low mid-transaction immediately forces all reset values, including mem_req = 0. The memory side must tolerate an aborted request on reset only.

## Test plan
- Reset, ack every cycle, ready = 1, mem bytes = address XOR 0x5A.
  - -> mem_addr steps 0,1,2,…
  - -> instr = 0x5A, 0x5B, 0x58 on consecutive cycles from cycle 2.
  - -> instr_pc matches each byte's address.
- Backpressure, ready = 0, ack every cycle.
  - -> exactly 2 acks accepted, then mem_req low and count = 2.
  - -> raising ready pops 0x00 then 0x01 and fetching resumes at 0x02.
- Jump while waiting, mem_req high at 0x05 with ack delayed 3 cycles, jump = 1 to 0x40.
  - -> mem_addr stays 0x05 until ack, and that byte is never presented.
  - -> next mem_addr = 0x40 and the first valid instr_pc = 0x40.
- Jump coincident with pop and ack: queue holds 2 entries, with jump, instr_ready and mem_ack all high in one cycle.
  - -> instr_valid low the next cycle and the acked byte is dropped.
  - -> fetch restarts at jump_addr.
- Wrap-around, RESET_ADDR = 0xFE.
  - -> fetched addresses 0xFE, 0xFF, 0x00, 0x01 with matching instr_pc.
- Reset mid-request, mem_req high at 0x03 with no ack and rst_n pulsed low.
  - -> mem_req = 0, instr_valid = 0 and mem_addr = RESET_ADDR during reset.
  - -> fetching restarts at RESET_ADDR afterwards.

Source files
------------

// File: rtl/instr_fetch_if.sv
// rtl/instr_fetch_if.sv - bus bundle for the SIMP instruction fetch stage
// Ports (signals):
//   mem_req/mem_addr      fetch request and address (driven by fetch stage)
//   mem_ack/mem_rdata     request completion pulse and instruction byte
//   instr/instr_pc        queue head byte and the address it came from
//   instr_valid           queue non-empty
//   instr_ready           decoder consumes the head this cycle
//   jump/jump_addr        redirect pulse and target address
// Modports: master = fetch stage, slave = memory/decoder/redirect side.
interface instr_fetch_if #(
  parameter int unsigned ADDR_W = 8
) ();
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic [7:0]        mem_rdata;
  logic [7:0]        instr;
  logic [ADDR_W-1:0] instr_pc;
  logic              instr_valid;
  logic              instr_ready;
  logic              jump;
  logic [ADDR_W-1:0] jump_addr;

  modport master (
    output mem_req, mem_addr, instr, instr_pc, instr_valid,
    input  mem_ack, mem_rdata, instr_ready, jump, jump_addr
  );

  modport slave (
    input  mem_req, mem_addr, instr, instr_pc, instr_valid,
    output mem_ack, mem_rdata, instr_ready, jump, jump_addr
  );
endinterface

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - SIMP instruction fetch stage with 2-entry prefetch queue
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    instr_fetch_if.master: memory req/ack port, decoder valid/ready
//          port and jump redirect
module instr_fetch #(
  parameter int unsigned       ADDR_W     = 8,
  parameter logic [ADDR_W-1:0] RESET_ADDR = '0
) (
  input  logic          clk,
  input  logic          rst_n,
  instr_fetch_if.master bus
);

  typedef enum logic [1:0] {IDLE, FETCH, DISCARD} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              mem_req_q, mem_req_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  // Queue is a 2-slot shift register with slot 0 as head. Slots beyond
  // count are kept at zero so the head registers can drive instr/instr_pc
  // directly and read as 0 when the queue is empty.
  logic [7:0]        byte0_q, byte0_d, byte1_q, byte1_d;
  logic [ADDR_W-1:0] addr0_q, addr0_d, addr1_q, addr1_d;
  logic [1:0]        count_q, count_d;
  logic              instr_valid_q, instr_valid_d;

  logic              ack;
  logic              pop;
  logic              push;
  logic [ADDR_W-1:0] pc_inc;

  assign ack    = mem_req_q & bus.mem_ack;
  // A jump flushes the queue, so any pop in the same cycle is meaningless.
  assign pop    = instr_valid_q & bus.instr_ready & ~bus.jump;
  // Only a FETCH-state completion carries a byte we keep; DISCARD drops it.
  assign push   = (state_q == FETCH) & ack & ~bus.jump;
  assign pc_inc = pc_q + ADDR_W'(1);

  always_comb begin
    byte0_d = byte0_q;
    byte1_d = byte1_q;
    addr0_d = addr0_q;
    addr1_d = addr1_q;
    count_d = count_q;
    if (bus.jump) begin
      byte0_d = '0;
      byte1_d = '0;
      addr0_d = '0;
      addr1_d = '0;
      count_d = 2'd0;
    end else begin
      if (pop) begin
        byte0_d = byte1_q;
        addr0_d = addr1_q;
        byte1_d = '0;
        addr1_d = '0;
        count_d = count_q - 2'd1;
      end
      // Issue rule guarantees a push never meets a full queue.
      if (push) begin
        if (count_d == 2'd0) begin
          byte0_d = bus.mem_rdata;
          addr0_d = mem_addr_q;
        end else begin
          byte1_d = bus.mem_rdata;
          addr1_d = mem_addr_q;
        end
        count_d = count_d + 2'd1;
      end
    end
    instr_valid_d = (count_d != 2'd0);
  end

  // A new request may start whenever the post-push/pop count leaves room,
  // since no request is outstanding at the point of issue.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    mem_req_d  = mem_req_q;
    mem_addr_d = mem_addr_q;
    case (state_q)
      IDLE: begin
        if (bus.jump) begin
          state_d    = FETCH;
          mem_req_d  = 1'b1;
          mem_addr_d = bus.jump_addr;
          pc_d       = bus.jump_addr;
        end else if (count_d != 2'd2) begin
          state_d    = FETCH;
          mem_req_d  = 1'b1;
          mem_addr_d = pc_q;
        end
      end
      FETCH: begin
        if (bus.jump) begin
          pc_d = bus.jump_addr;
          if (ack) begin
            // Returned byte is dropped; restart immediately at the target.
            mem_addr_d = bus.jump_addr;
          end else begin
            // Request cannot be withdrawn: keep req/addr until it completes.
            state_d = DISCARD;
          end
        end else if (ack) begin
          pc_d       = pc_inc;
          mem_addr_d = pc_inc;
          if (count_d == 2'd2) begin
            state_d   = IDLE;
            mem_req_d = 1'b0;
          end
        end
      end
      DISCARD: begin
        if (bus.jump) begin
          pc_d = bus.jump_addr;
        end
        if (ack) begin
          state_d    = FETCH;
          mem_addr_d = bus.jump ? bus.jump_addr : pc_q;
        end
      end
      default: begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      pc_q          <= RESET_ADDR;
      mem_req_q     <= 1'b0;
      mem_addr_q    <= RESET_ADDR;
      byte0_q       <= '0;
      byte1_q       <= '0;
      addr0_q       <= '0;
      addr1_q       <= '0;
      count_q       <= 2'd0;
      instr_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      mem_req_q     <= mem_req_d;
      mem_addr_q    <= mem_addr_d;
      byte0_q       <= byte0_d;
      byte1_q       <= byte1_d;
      addr0_q       <= addr0_d;
      addr1_q       <= addr1_d;
      count_q       <= count_d;
      instr_valid_q <= instr_valid_d;
    end
  end

  assign bus.mem_req     = mem_req_q;
  assign bus.mem_addr    = mem_addr_q;
  assign bus.instr       = byte0_q;
  assign bus.instr_pc    = addr0_q;
  assign bus.instr_valid = instr_valid_q;

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - self-checking bench for instr_fetch
module tb_instr_fetch;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  instr_fetch_if #(.ADDR_W(8)) bus_a ();
  instr_fetch_if #(.ADDR_W(8)) bus_b ();

  instr_fetch #(.ADDR_W(8), .RESET_ADDR(8'h00)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_a.master)
  );

  instr_fetch #(.ADDR_W(8), .RESET_ADDR(8'hFE)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_b.master)
  );

  typedef struct {
    bit         rst;
    bit         ack;
    logic [7:0] rdata;
    bit         ready;
    bit         jump;
    logic [7:0] jaddr;
    bit         e_req;
    logic [7:0] e_addr;
    bit         e_valid;
    logic [7:0] e_instr;
    logic [7:0] e_pc;
  } vec_t;

  vec_t vecs[$];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  function automatic void add(bit rst, bit ack, logic [7:0] rdata, bit ready, bit jump,
                              logic [7:0] jaddr, bit e_req, logic [7:0] e_addr,
                              bit e_valid, logic [7:0] e_instr, logic [7:0] e_pc);
    vec_t v;
    v.rst = rst; v.ack = ack; v.rdata = rdata; v.ready = ready; v.jump = jump;
    v.jaddr = jaddr; v.e_req = e_req; v.e_addr = e_addr; v.e_valid = e_valid;
    v.e_instr = e_instr; v.e_pc = e_pc;
    vecs.push_back(v);
  endfunction

  task automatic idle_inputs();
    bus_a.mem_ack = 1'b0; bus_a.mem_rdata = 8'h00; bus_a.instr_ready = 1'b0;
    bus_a.jump = 1'b0; bus_a.jump_addr = 8'h00;
    bus_b.mem_ack = 1'b0; bus_b.mem_rdata = 8'h00; bus_b.instr_ready = 1'b0;
    bus_b.jump = 1'b0; bus_b.jump_addr = 8'h00;
  endtask

  // Returns at a negedge with rst_n just released (cycle 0 after reset).
  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_req",    bus_a.mem_req,     1'b0);
    chk("rst_addr",   bus_a.mem_addr,    8'h00);
    chk("rst_valid",  bus_a.instr_valid, 1'b0);
    chk("rst_instr",  bus_a.instr,       8'h00);
    chk("rst_pc",     bus_a.instr_pc,    8'h00);
    chk("rst_b_addr", bus_b.mem_addr,    8'hFE);
    chk("rst_b_req",  bus_b.mem_req,     1'b0);
    rst_n = 1'b1;
  endtask

  // Memory model returning addr^0x5A with zero wait, until the request sits at target.
  task automatic run_to_addr(input logic [7:0] target, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (bus_a.mem_req && bus_a.mem_addr == target) begin
        ok = 1'b1;
      end else begin
        bus_a.mem_ack   = bus_a.mem_req;
        bus_a.mem_rdata = bus_a.mem_addr ^ 8'h5A;
        @(negedge clk);
      end
    end
    bus_a.mem_ack = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    bit ok;
    logic [7:0] wrap_addr [4];
    idle_inputs();

    // rst ack rdata ready jump jaddr | req addr valid instr pc
    // Streaming, ready held high, byte = addr ^ 0x5A.
    add(1, 1, 8'h5A, 1, 0, 8'h00,  0, 8'h00, 0, 8'h00, 8'h00);
    add(0, 1, 8'h5A, 1, 0, 8'h00,  1, 8'h00, 0, 8'h00, 8'h00);
    add(0, 1, 8'h5B, 1, 0, 8'h00,  1, 8'h01, 1, 8'h5A, 8'h00);
    add(0, 1, 8'h58, 1, 0, 8'h00,  1, 8'h02, 1, 8'h5B, 8'h01);
    add(0, 1, 8'h59, 1, 0, 8'h00,  1, 8'h03, 1, 8'h58, 8'h02);
    add(0, 0, 8'h00, 1, 0, 8'h00,  1, 8'h04, 1, 8'h59, 8'h03);
    add(0, 0, 8'h00, 0, 0, 8'h00,  1, 8'h04, 0, 8'h00, 8'h00);
    // Backpressure: two acks fill the queue, then release ready.
    add(1, 1, 8'h5A, 0, 0, 8'h00,  0, 8'h00, 0, 8'h00, 8'h00);
    add(0, 1, 8'h5A, 0, 0, 8'h00,  1, 8'h00, 0, 8'h00, 8'h00);
    add(0, 1, 8'h5B, 0, 0, 8'h00,  1, 8'h01, 1, 8'h5A, 8'h00);
    add(0, 1, 8'h58, 0, 0, 8'h00,  0, 8'h02, 1, 8'h5A, 8'h00);
    add(0, 1, 8'h58, 1, 0, 8'h00,  0, 8'h02, 1, 8'h5A, 8'h00);
    add(0, 1, 8'h58, 1, 0, 8'h00,  1, 8'h02, 1, 8'h5B, 8'h01);
    add(0, 0, 8'h00, 0, 0, 8'h00,  1, 8'h03, 1, 8'h58, 8'h02);
    // Jump with ack and pop in FETCH: byte 0x59 dropped, restart at 0x20.
    add(0, 1, 8'h59, 1, 1, 8'h20,  1, 8'h03, 1, 8'h58, 8'h02);
    add(0, 1, 8'h7A, 0, 0, 8'h00,  1, 8'h20, 0, 8'h00, 8'h00);
    add(0, 0, 8'h00, 0, 0, 8'h00,  1, 8'h21, 1, 8'h7A, 8'h20);

    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].rst) do_reset();
      chk($sformatf("v%0d_req", i), bus_a.mem_req, vecs[i].e_req);
      if (vecs[i].e_req) chk($sformatf("v%0d_addr", i), bus_a.mem_addr, vecs[i].e_addr);
      chk($sformatf("v%0d_valid", i), bus_a.instr_valid, vecs[i].e_valid);
      chk($sformatf("v%0d_instr", i), bus_a.instr, vecs[i].e_instr);
      chk($sformatf("v%0d_pc", i), bus_a.instr_pc, vecs[i].e_pc);
      bus_a.mem_ack     = vecs[i].ack;
      bus_a.mem_rdata   = vecs[i].rdata;
      bus_a.instr_ready = vecs[i].ready;
      bus_a.jump        = vecs[i].jump;
      bus_a.jump_addr   = vecs[i].jaddr;
      @(negedge clk);
    end
    idle_inputs();

    // Jump while waiting for ack at 0x05.
    do_reset();
    bus_a.instr_ready = 1'b1;
    run_to_addr(8'h05, ok);
    chk("jw_reach_05", ok, 1'b1);
    bus_a.jump = 1'b1; bus_a.jump_addr = 8'h40;
    @(negedge clk);
    bus_a.jump = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("jw_hold_req%0d", k), bus_a.mem_req, 1'b1);
      chk($sformatf("jw_hold_addr%0d", k), bus_a.mem_addr, 8'h05);
      chk($sformatf("jw_hold_valid%0d", k), bus_a.instr_valid, 1'b0);
      if (k < 2) @(negedge clk);
    end
    bus_a.mem_ack = 1'b1; bus_a.mem_rdata = 8'hEE;
    @(negedge clk);
    bus_a.mem_ack = 1'b0;
    chk("jw_valid_after_ack", bus_a.instr_valid, 1'b0);
    chk("jw_req_40", bus_a.mem_req, 1'b1);
    chk("jw_addr_40", bus_a.mem_addr, 8'h40);
    bus_a.mem_ack = 1'b1; bus_a.mem_rdata = 8'h77;
    @(negedge clk);
    bus_a.mem_ack = 1'b0;
    chk("jw_valid", bus_a.instr_valid, 1'b1);
    chk("jw_instr", bus_a.instr, 8'h77);
    chk("jw_pc", bus_a.instr_pc, 8'h40);
    idle_inputs();

    // Jump coincident with pop and (ignored) ack while queue is full.
    do_reset();
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (bus_a.instr_valid && !bus_a.mem_req) begin
        ok = 1'b1;
      end else begin
        bus_a.mem_ack   = bus_a.mem_req;
        bus_a.mem_rdata = bus_a.mem_addr ^ 8'h5A;
        @(negedge clk);
      end
    end
    chk("jc_full", ok, 1'b1);
    chk("jc_head", bus_a.instr, 8'h5A);
    bus_a.jump = 1'b1; bus_a.jump_addr = 8'h80; bus_a.instr_ready = 1'b1;
    bus_a.mem_ack = 1'b1; bus_a.mem_rdata = 8'hCC;
    @(negedge clk);
    bus_a.jump = 1'b0; bus_a.mem_ack = 1'b0; bus_a.instr_ready = 1'b0;
    chk("jc_valid", bus_a.instr_valid, 1'b0);
    chk("jc_instr", bus_a.instr, 8'h00);
    chk("jc_req", bus_a.mem_req, 1'b1);
    chk("jc_addr", bus_a.mem_addr, 8'h80);
    bus_a.mem_ack = 1'b1; bus_a.mem_rdata = 8'h11;
    @(negedge clk);
    bus_a.mem_ack = 1'b0;
    chk("jc_new_valid", bus_a.instr_valid, 1'b1);
    chk("jc_new_instr", bus_a.instr, 8'h11);
    chk("jc_new_pc", bus_a.instr_pc, 8'h80);
    idle_inputs();

    // Wrap-around on the instance reset to 0xFE.
    wrap_addr = '{8'hFE, 8'hFF, 8'h00, 8'h01};
    do_reset();
    bus_b.instr_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      if (c >= 1 && c <= 4) begin
        chk($sformatf("wr_req%0d", c), bus_b.mem_req, 1'b1);
        chk($sformatf("wr_addr%0d", c), bus_b.mem_addr, wrap_addr[c-1]);
      end
      if (c >= 2) begin
        chk($sformatf("wr_valid%0d", c), bus_b.instr_valid, 1'b1);
        chk($sformatf("wr_pc%0d", c), bus_b.instr_pc, wrap_addr[c-2]);
        chk($sformatf("wr_instr%0d", c), bus_b.instr, wrap_addr[c-2] ^ 8'h5A);
      end
      bus_b.mem_ack   = (c >= 1 && c <= 4);
      bus_b.mem_rdata = (c >= 1 && c <= 4) ? (wrap_addr[c-1] ^ 8'h5A) : 8'h00;
      @(negedge clk);
    end
    idle_inputs();

    // Reset asserted mid-request at 0x03.
    do_reset();
    bus_a.instr_ready = 1'b1;
    run_to_addr(8'h03, ok);
    chk("rm_reach_03", ok, 1'b1);
    @(negedge clk);
    chk("rm_wait_req", bus_a.mem_req, 1'b1);
    chk("rm_wait_addr", bus_a.mem_addr, 8'h03);
    #2 rst_n = 1'b0;
    #1;
    chk("rm_async_req", bus_a.mem_req, 1'b0);
    chk("rm_async_valid", bus_a.instr_valid, 1'b0);
    chk("rm_async_addr", bus_a.mem_addr, 8'h00);
    @(negedge clk);
    chk("rm_in_rst_req", bus_a.mem_req, 1'b0);
    chk("rm_in_rst_pc", bus_a.instr_pc, 8'h00);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rm_restart_req", bus_a.mem_req, 1'b1);
    chk("rm_restart_addr", bus_a.mem_addr, 8'h00);
    idle_inputs();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
